poly_addsub_stream: RTL and testbench
=====================================

# poly_addsub_stream

Streams a full polynomial through a modular add/subtract datapath. It reads coefficient pairs from two single-cycle-latency coefficient RAMs and writes `(a ± b) mod Q` back through a write port. It is the parametrised, whole-polynomial successor to the single-coefficient subtract unit and serves the NewHope encrypt/decrypt paths (`v - s·u`, `b + e`, etc.). Reduction is a single conditional subtraction, so there is no multiplier.

## Interface
- `N`, 1024: coefficients per polynomial; power of two.
- `ADDR_W`, 10: address width; equals log2(N).
- `W`, 14: coefficient width; Q < 2^W.
- `Q`, 12289: modulus.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request, accepted only when idle.
- `mode` in 2: 00 a+b, 01 a−b, 10 b−a, 11 treated as 00; latched at accept.
- `en` in 1: pipeline advance; low freezes the whole block.
- `rd_en` out 1: read strobe to both RAMs.
- `rd_addr` out ADDR_W: read address shared by both RAMs.
- `dia`, `dib` in W: RAM outputs, valid the cycle after `rd_en`; RAM holds output while `rd_en` is low.
- `wr_en` out 1: result write strobe.
- `wr_addr` out ADDR_W: result address.
- `dout` out W: result coefficient.
- `busy` out 1: high from accept until `done`.
- `done` out 1: one-cycle pulse after the last write.

## Operation
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE: `start`=1 moves to RUN; `mode` is latched and the read counter is cleared.
  - RUN: one read per `en` cycle, addresses 0..N−1 ascending. After address N−1 is issued, go to DRAIN.
  - DRAIN: wait until the last write has been issued, then go to FIN.
  - FIN: `done`=1 for one cycle, then IDLE.
- `start` while `busy` is ignored and has no effect on the current job.
- Pipeline:
  - S0: issue the read.
  - S1: capture `dia`/`dib` and compute the raw W+1-bit value.
    - 00: `a + b`
    - 01: `a + Q − b`
    - 10: `b + Q − a`
  - S2: if raw ≥ Q, output raw − Q, else raw. Register the result into `dout`/`wr_addr`/`wr_en`.
- Valid and address travel in a shift chain alongside the data. `wr_addr` equals the `rd_addr` of the same element.
- Inputs must be < Q. Under that precondition the output is in [0, Q−1]. For out-of-range inputs the output is exactly the formula above, truncated to W bits, with no check.
- `en`=0:
  - All state, counters and pipeline registers hold.
  - `rd_en` and `wr_en` are forced to 0.
  - `done` stays pending and is not dropped.
  - Resume is seamless, with no duplicated or skipped address.
- In-place operation (writes into RAM A) is safe: the write to address k happens after the read of k.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `wr_en`=0, `wr_addr`=0, `dout`=0, `busy`=0, `done`=0, FSM in IDLE, `mode` register = 00.
- Reset is asynchronous: asserting it mid-job aborts immediately. No further writes and no `done`.
- With `en` held high and `start` accepted at edge E:
  - `busy` is high from E.
  - `rd_en`=1 with address k in cycle E+k, for k = 0..N−1.
  - `wr_en`=1 with `wr_addr` k in cycle E+k+2.
  - The last write is in cycle E+N+1.
  - `done` is in cycle E+N+2; `busy` falls together with `done` deasserting at E+N+3.
- Total: N+3 cycles from accept to idle. Throughput is 1 coefficient/cycle.
- Cycles with `en`=0 add exactly one cycle each to every later event.
- A `start` in the cycle `done` is high is ignored. The next accept is possible from the first IDLE cycle.

## Test plan
- Add, N=8 (override): a=[0,1,12288,6000,…], b=[0,12288,12288,6289,…], mode=00 → dout=[0,0,12287,0,…], writes at E+2..E+9, `done` at E+10.
- Subtract and reverse subtract: a=5, b=7 with mode=01 → 12287; mode=10 → 2; a=b=12288 → 0 for both; mode=11 behaves as 00.
- Full N=1024 random in-range vectors, all modes, checked against a reference model.
  - Every address written exactly once, in ascending order.
  - All outputs < Q.
- `en` toggled pseudo-randomly (including `en`=0 while `done` is pending) → same results and order; `done` delayed by exactly the count of `en`=0 cycles.
- `start` pulsed mid-job and in the `done` cycle → ignored; a `mode` change mid-job does not affect results.
- `rst` asserted at write 5 → all outputs 0 asynchronously, no `done`; a new `start` after release runs cleanly from address 0.

Source files
------------

// File: rtl/poly_addsub_stream.sv
// Whole-polynomial modular add/subtract stream.
// Reads a/b coefficient pairs, writes (a +/- b) mod Q.
module poly_addsub_stream #(
  parameter int N      = 1024,
  parameter int ADDR_W = 10,
  parameter int W      = 14,
  parameter int Q      = 12289
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [W-1:0]      dia,
  input  logic [W-1:0]      dib,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [W-1:0]      dout,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  localparam logic [W:0]        QX   = (W + 1)'(Q);

  state_t            state;
  logic [1:0]        mode_q;
  logic              rd_v;
  logic              v1;
  logic [ADDR_W-1:0] addr1;
  logic              wr_v;
  logic [W:0]        a_x;
  logic [W:0]        b_x;
  logic [W:0]        raw_c;
  logic [W:0]        red_c;

  assign rd_en = rd_v & en;
  assign wr_en = wr_v & en;

  // raw sum/difference of the RAM outputs, then one conditional subtract
  always_comb begin
    a_x   = {1'b0, dia};
    b_x   = {1'b0, dib};
    raw_c = a_x + b_x;
    unique case (1'b1)
      mode_q == 2'b01: raw_c = a_x + QX - b_x;
      mode_q == 2'b10: raw_c = b_x + QX - a_x;
      default:         raw_c = a_x + b_x;
    endcase
    red_c = (raw_c >= QX) ? raw_c - QX : raw_c;
  end

  // job control: accept, address sweep, drain, done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mode_q  <= 2'b00;
      rd_v    <= 1'b0;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (en) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            mode_q  <= (mode == 2'b11) ? 2'b00 : mode;
            rd_v    <= 1'b1;
            rd_addr <= '0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          if (rd_addr == LAST) begin
            rd_v  <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (wr_v && wr_addr == LAST) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // valid/address shift chain and registered result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1      <= 1'b0;
      addr1   <= '0;
      wr_v    <= 1'b0;
      wr_addr <= '0;
      dout    <= '0;
    end else if (en) begin
      v1      <= rd_v;
      addr1   <= rd_addr;
      wr_v    <= v1;
      wr_addr <= addr1;
      if (v1) dout <= red_c[W-1:0];
    end
  end

endmodule

// File: tb/tb_poly_addsub_stream.sv
// Scoreboard bench for poly_addsub_stream.
// Random RAM contents, random en stalls, abort by reset.
module tb_poly_addsub_stream;

  localparam int N  = 1024;
  localparam int AW = 10;
  localparam int W  = 14;
  localparam int Q  = 12289;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          en = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  dia = '0;
  logic [W-1:0]  dib = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  dout;
  logic          busy;
  logic          done;

  typedef struct {
    int addr;
    int val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   stall_on = 1'b0;
  int   mem_a[N];
  int   mem_b[N];

  always #5 clk = ~clk;

  poly_addsub_stream #(
    .N(N), .ADDR_W(AW), .W(W), .Q(Q)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .mode(mode), .en(en),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .dia(dia), .dib(dib),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .dout(dout), .busy(busy), .done(done)
  );

  // single-cycle-latency RAMs, holding output when not read
  always @(posedge clk) begin
    if (rd_en === 1'b1) begin
      dia <= W'(mem_a[rd_addr]);
      dib <= W'(mem_b[rd_addr]);
    end
  end

  // en driver: steady high or pseudo-random stalls
  always @(negedge clk) begin
    en = stall_on ? ($urandom_range(3) != 0) : 1'b1;
  end

  function automatic void check(string n, longint got, longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endfunction

  function automatic int ref_val(int a, int b, int m);
    case (m)
      1:       return ((a - b) % Q + Q) % Q;
      2:       return ((b - a) % Q + Q) % Q;
      default: return (a + b) % Q;
    endcase
  endfunction

  // monitor: every strobed write must match the head of the scoreboard
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = sb.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("dout", dout, e.val);
        check("dout_lt_q", (dout < Q) ? 1 : 0, 1);
      end
    end
  end

  task automatic fill();
    for (int i = 0; i < N; i++) begin
      mem_a[i] = $urandom_range(Q - 1);
      mem_b[i] = $urandom_range(Q - 1);
    end
  endtask

  task automatic push_exp(input int m);
    int mm;
    mm = (m == 3) ? 0 : m;
    for (int i = 0; i < N; i++)
      sb.push_back('{i, ref_val(mem_a[i], mem_b[i], mm)});
  endtask

  task automatic accept(input int m);
    @(negedge clk);
    start = 1'b1;
    mode = 2'(m);
    @(posedge clk);
    while (!en) @(posedge clk);
  endtask

  task automatic run_job(input int m, input bit chatter);
    int act;
    int cyc;
    int first_wr;
    int last_wr;
    push_exp(m);
    accept(m);
    act = 1;
    cyc = 0;
    first_wr = -1;
    last_wr = -1;
    forever begin
      @(negedge clk);
      #2;
      if (wr_en === 1'b1) begin
        if (first_wr < 0) first_wr = act;
        last_wr = act;
      end
      if (cyc == 0) check("busy_on", busy, 1);
      start = chatter && ($urandom_range(7) == 0);
      mode = 2'($urandom_range(3));
      if (done === 1'b1) break;
      cyc++;
      if (cyc > 20 * N) begin
        check("done_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      if (en) act++;
    end
    check("first_write_edges", first_wr, 3);
    check("last_write_edges", last_wr, N + 2);
    check("done_edges", act, N + 3);
    start = 1'b1;
    @(posedge clk);
    while (!en) @(posedge clk);
    @(negedge clk);
    #2;
    start = 1'b0;
    check("done_pulse", done, 0);
    check("busy_off", busy, 0);
    @(posedge clk);
    while (!en) @(posedge clk);
    @(negedge clk);
    #2;
    check("start_in_done_ignored", busy, 0);
    check("sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  task automatic abort_job();
    int cyc;
    int seen;
    fill();
    push_exp(1);
    accept(1);
    cyc = 0;
    forever begin
      @(negedge clk);
      #2;
      start = 1'b0;
      if (wr_en === 1'b1 && wr_addr == 5) break;
      cyc++;
      if (cyc > 100) begin
        check("write5_timeout", 0, 1);
        break;
      end
    end
    rst = 1'b0;
    #1;
    check("abort_rd_en", rd_en, 0);
    check("abort_rd_addr", rd_addr, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_wr_addr", wr_addr, 0);
    check("abort_dout", dout, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      #2;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("no_done_after_abort", seen, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2;
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;

    fill();
    mem_a[0] = 0;     mem_b[0] = 0;
    mem_a[1] = 1;     mem_b[1] = 12288;
    mem_a[2] = 12288; mem_b[2] = 12288;
    mem_a[3] = 6000;  mem_b[3] = 6289;
    run_job(0, 1'b0);
    run_job(3, 1'b0);

    fill();
    mem_a[0] = 5;     mem_b[0] = 7;
    mem_a[1] = 12288; mem_b[1] = 12288;
    mem_a[2] = 0;     mem_b[2] = 12288;
    run_job(1, 1'b0);
    run_job(2, 1'b0);

    stall_on = 1'b1;
    for (int j = 0; j < 3; j++) begin
      fill();
      run_job(j, 1'b1);
    end
    stall_on = 1'b0;

    abort_job();
    fill();
    run_job(2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
